pulse_channel: RTL and testbench
================================

# pulse_channel

Single-voice square-wave synthesizer channel with a per-note volume envelope, used inside the music sequencer. It latches a note row (note_on, note_trigger, phase_inc) once per song step and advances a phase accumulator on each sample strobe. It releases the envelope on each tick strobe and outputs an unsigned 13-bit sample for summing with other channels.

## Interface
- PHASE_BITS, default 18: width of the phase accumulator and of phase_inc; the square output is the accumulator MSB.
- RELEASE, default 2: release shift; larger values give a slower decay.
- clk  input  1  system clock. Reset rst_n, synchronous, active-low; clock clk.
- rst_n  input  1  synchronous active-low reset.
- sample_clk  input  1  one-clk-cycle strobe; advances the phase accumulator.
- tick_clk  input  1  one-clk-cycle strobe; envelope update rate.
- song_clk  input  1  level; high on the last tick of a song step. It is only meaningful together with tick_clk.
- note_on  input  1  row gate; 1 means sustain, 0 means release.
- note_trigger  input  1  row retrigger; restarts phase and envelope.
- phase_inc  input  PHASE_BITS  row pitch increment per sample.
- audio_out  output  13  unsigned sample, range 0..4080.

## Operation
- State: phase[PHASE_BITS-1:0], vol[7:0], gate, inc[PHASE_BITS-1:0], row_pending.
- Row latch:
  - A cycle with tick_clk && song_clk sets row_pending. The sequencer advances its row on that same edge.
  - On the next clk cycle with row_pending=1: gate <= note_on and inc <= phase_inc. If note_trigger=1, also phase <= 0 and vol <= 255. Then row_pending <= 0.
  - The inputs on all other cycles are ignored.
- Phase: on each sample_clk, phase <= phase + inc, wrapping modulo 2^PHASE_BITS.
- Envelope, on each tick_clk:
  - If gate=1, vol is held (sustain). There is no re-attack without a trigger.
  - If gate=0, vol <= vol - dec, where dec = vol >> RELEASE. If dec is 0 and vol is nonzero, dec = 1. vol=0 stays 0.
- Output: audio_out = phase[PHASE_BITS-1] ? {1'b0, vol, 4'b0} : 13'd0.
  - It is combinational from the registered state.
  - The maximum is 4080, so two channels sum into 13 bits without overflow.
- A trigger with note_on=0 attacks to 255 and decays from the next tick.
- note_on=1 with no trigger keeps the current vol and phase and adopts the new inc.

## Timing
- Reset values: phase=0, vol=0, gate=0, inc=0, row_pending=0, audio_out=0.
  - Reset mid-note silences the output on the next cycle.
- Row latch latency: exactly 1 clk after the tick_clk && song_clk edge. Effects are visible on audio_out in the cycle after the latch edge.
- Conflicts on the latch cycle:
  - A trigger overrides a concurrent sample_clk phase step, so phase ends at 0.
  - A trigger overrides a concurrent tick_clk decay, so vol ends at 255.
  - Without a trigger, a concurrent sample_clk uses the old inc and a concurrent tick_clk uses the old gate.
- song_clk high without tick_clk does nothing.
- A new tick_clk && song_clk while row_pending=1 keeps it set; there is a single latch.
- All updates are on the rising edge of clk; there are no other clocks.

## Test plan
- Reset: hold rst_n=0 with all strobes toggling -> audio_out=0, phase=0, vol=0; release reset and idle -> audio_out stays 0.
- Trigger and pitch (PHASE_BITS=18):
  - Stimulus: row note_on=1, trigger=1, phase_inc=0x200, then sample_clk every cycle.
  - Required: vol=255; MSB toggles every 256 samples; audio_out alternates 0 and 4080.
- Sustain and release (RELEASE=2):
  - Stimulus: after the trigger, a row with note_on=0, trigger=0.
  - Required vol per tick: 255, 192, 144, 108, 81, 61, 46, …; vol goes to 3, 2, 1, 0 by steps of 1 and stays 0.
- Latch timing: change note_on one cycle before, on, and two cycles after the tick_clk&&song_clk edge -> only the value present on the cycle after the edge is latched.
- Conflicts on the latch cycle:
  - Stimulus: trigger row with sample_clk=1 and tick_clk=1 in the same cycle.
  - Required: phase=0 and vol=255 after that edge.
- PHASE_BITS=14, phase_inc=0x3FF: the accumulator wraps modulo 16384 and the MSB period is ~16 samples.

Source files
------------

// File: rtl/pulse_channel.sv
// Square-wave synthesizer voice: a row latched once per song step sets pitch and gate,
// a phase accumulator runs on sample strobes and a shift-based release envelope runs on ticks.
module pulse_channel #(
  parameter int PHASE_BITS = 18,
  parameter int RELEASE    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_clk,
  input  logic                  tick_clk,
  input  logic                  song_clk,
  input  logic                  note_on,
  input  logic                  note_trigger,
  input  logic [PHASE_BITS-1:0] phase_inc,
  output logic [12:0]           audio_out
);

  logic [PHASE_BITS-1:0] phase_r;
  logic [PHASE_BITS-1:0] inc_r;
  logic [7:0]            vol_r;
  logic                  gate_r;
  logic                  row_pending_r;
  logic                  retrigger_s;

  // One release step; a nonzero volume always drops by at least one so it reaches silence.
  function automatic logic [7:0] release_step(input logic [7:0] vol);
    logic [7:0] dec;
    dec = vol >> RELEASE;
    if ((dec == 8'd0) && (vol != 8'd0)) begin
      dec = 8'd1;
    end else begin
      dec = dec;
    end
    return vol - dec;
  endfunction

  assign retrigger_s = row_pending_r & note_trigger;

  // Row latch, phase accumulator and envelope; a trigger wins over same-cycle strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_r       <= '0;
      inc_r         <= '0;
      vol_r         <= 8'd0;
      gate_r        <= 1'b0;
      row_pending_r <= 1'b0;
    end else begin
      if (tick_clk && song_clk) begin
        row_pending_r <= 1'b1;
      end else begin
        row_pending_r <= 1'b0;
      end

      if (row_pending_r) begin
        gate_r <= note_on;
        inc_r  <= phase_inc;
      end

      if (retrigger_s) begin
        phase_r <= '0;
      end else if (sample_clk) begin
        phase_r <= phase_r + inc_r;
      end

      if (retrigger_s) begin
        vol_r <= 8'd255;
      end else if (tick_clk && !gate_r) begin
        vol_r <= release_step(vol_r);
      end
    end
  end

  // Volume scaled by 16 keeps the peak at 4080 so two voices sum without overflow.
  assign audio_out = phase_r[PHASE_BITS-1] ? {1'b0, vol_r, 4'b0000} : 13'd0;

endmodule

// File: tb/tb_pulse_channel.sv
// Self-checking bench for pulse_channel: a default instance (18-bit phase) and a 14-bit instance
// share the strobes; expected samples go through a scoreboard queue.
module tb_pulse_channel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_clk;
  logic        tick_clk;
  logic        song_clk;
  logic        note_on;
  logic        note_trigger;
  logic [17:0] phase_inc;
  logic [13:0] phase_inc14;
  logic [12:0] audio_out;
  logic [12:0] audio_out14;

  int checks = 0;
  int passed = 0;
  logic [12:0] exp_q[$];
  logic [12:0] exp_v;

  pulse_channel dut (
    .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk), .tick_clk(tick_clk),
    .song_clk(song_clk), .note_on(note_on), .note_trigger(note_trigger),
    .phase_inc(phase_inc), .audio_out(audio_out)
  );

  pulse_channel #(.PHASE_BITS(14), .RELEASE(2)) dut14 (
    .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk), .tick_clk(tick_clk),
    .song_clk(song_clk), .note_on(note_on), .note_trigger(note_trigger),
    .phase_inc(phase_inc14), .audio_out(audio_out14)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Strobe edge, then the latch cycle with the row; afterwards the row inputs carry junk.
  task automatic latch_row(input logic on, input logic trig, input logic [17:0] inc,
                           input logic [13:0] inc14);
    tick_clk = 1'b1; song_clk = 1'b1;
    cyc();
    tick_clk = 1'b0; song_clk = 1'b0;
    note_on = on; note_trigger = trig; phase_inc = inc; phase_inc14 = inc14;
    cyc();
    note_on = ~on; note_trigger = 1'b0; phase_inc = ~inc; phase_inc14 = ~inc14;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample_clk = 1'($urandom); tick_clk = 1'($urandom); song_clk = 1'($urandom);
      note_on = 1'($urandom); note_trigger = 1'($urandom); phase_inc = 18'($urandom);
      phase_inc14 = 14'($urandom);
      cyc();
      checks++;
      if (audio_out !== 13'd0) $display("FAIL reset_audio: got %0d expected 0", audio_out);
      else passed++;
    end
    checks++;
    if (dut.phase_r !== 18'd0 || dut.vol_r !== 8'd0)
      $display("FAIL reset_state: phase %0h vol %0d expected 0 0", dut.phase_r, dut.vol_r);
    else passed++;
    sample_clk = 1'b0; tick_clk = 1'b0; song_clk = 1'b0; note_trigger = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (audio_out !== 13'd0) $display("FAIL idle_audio: got %0d expected 0", audio_out);
      else passed++;
    end
  endtask

  task automatic test_trigger_pitch();
    latch_row(1'b1, 1'b1, 18'h00200, 14'h0000);
    checks++;
    if (audio_out !== 13'd0 || dut.vol_r !== 8'd255)
      $display("FAIL trig_state: audio %0d vol %0d expected 0 255", audio_out, dut.vol_r);
    else passed++;
    sample_clk = 1'b1;
    for (int n = 1; n <= 600; n++) begin
      exp_q.push_back((((n >> 8) & 1) != 0) ? 13'd4080 : 13'd0);
      cyc();
      exp_v = exp_q.pop_front();
      checks++;
      if (audio_out !== exp_v)
        $display("FAIL pitch_sample%0d: got %0d expected %0d", n, audio_out, exp_v);
      else passed++;
    end
    sample_clk = 1'b0;
  endtask

  task automatic test_release();
    int vols[22] = '{255, 192, 144, 108, 81, 61, 46, 35, 27, 21, 16, 12, 9, 7, 6, 5, 4, 3, 2, 1, 0, 0};
    latch_row(1'b1, 1'b1, 18'h20000, 14'h0000);
    sample_clk = 1'b1; cyc(); sample_clk = 1'b0;
    tick_clk = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (audio_out !== 13'd4080) $display("FAIL sustain_tick%0d: got %0d expected 4080", i, audio_out);
      else passed++;
    end
    tick_clk = 1'b0;
    latch_row(1'b0, 1'b0, 18'h00000, 14'h0000);
    for (int i = 0; i < 22; i++) exp_q.push_back(13'(vols[i] * 16));
    exp_v = exp_q.pop_front();
    checks++;
    if (audio_out !== exp_v) $display("FAIL release_start: got %0d expected %0d", audio_out, exp_v);
    else passed++;
    for (int i = 1; i < 22; i++) begin
      tick_clk = 1'b1; cyc(); tick_clk = 1'b0;
      exp_v = exp_q.pop_front();
      checks++;
      if (audio_out !== exp_v) $display("FAIL release_tick%0d: got %0d expected %0d", i, audio_out, exp_v);
      else passed++;
    end
  endtask

  // note_on takes one value before/on the strobe edge, another on the latch cycle, another after.
  task automatic timed_row(input logic around, input logic at_latch);
    note_trigger = 1'b0; phase_inc = 18'h0;
    note_on = around; cyc();
    tick_clk = 1'b1; song_clk = 1'b1; cyc();
    tick_clk = 1'b0; song_clk = 1'b0; note_on = at_latch; cyc();
    note_on = around; cyc(); cyc();
  endtask

  task automatic test_latch_timing();
    latch_row(1'b1, 1'b1, 18'h20000, 14'h0000);
    sample_clk = 1'b1; cyc(); sample_clk = 1'b0;
    timed_row(1'b0, 1'b1);
    tick_clk = 1'b1; cyc(); tick_clk = 1'b0;
    checks++;
    if (audio_out !== 13'd4080) $display("FAIL latch_gate_on: got %0d expected 4080", audio_out);
    else passed++;
    timed_row(1'b1, 1'b0);
    tick_clk = 1'b1; cyc(); tick_clk = 1'b0;
    checks++;
    if (audio_out !== 13'd3072) $display("FAIL latch_gate_off: got %0d expected 3072", audio_out);
    else passed++;
  endtask

  task automatic test_conflicts();
    song_clk = 1'b1; note_on = 1'b1; note_trigger = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (audio_out !== 13'd3072) $display("FAIL song_only%0d: got %0d expected 3072", i, audio_out);
      else passed++;
    end
    song_clk = 1'b0; note_trigger = 1'b0;
    tick_clk = 1'b1; song_clk = 1'b1; cyc();
    song_clk = 1'b0;
    note_on = 1'b0; note_trigger = 1'b1; phase_inc = 18'h20000; sample_clk = 1'b1;
    checks++;
    if (audio_out !== 13'd2304) $display("FAIL before_latch: got %0d expected 2304", audio_out);
    else passed++;
    cyc();
    tick_clk = 1'b0; note_trigger = 1'b0;
    checks++;
    if (audio_out !== 13'd0 || dut.phase_r !== 18'd0 || dut.vol_r !== 8'd255)
      $display("FAIL trig_conflict: audio %0d phase %0h vol %0d expected 0 0 255",
               audio_out, dut.phase_r, dut.vol_r);
    else passed++;
    cyc(); sample_clk = 1'b0;
    checks++;
    if (audio_out !== 13'd4080) $display("FAIL trig_attack: got %0d expected 4080", audio_out);
    else passed++;
    tick_clk = 1'b1; cyc(); tick_clk = 1'b0;
    checks++;
    if (audio_out !== 13'd3072) $display("FAIL trig_decay: got %0d expected 3072", audio_out);
    else passed++;
    tick_clk = 1'b1; song_clk = 1'b1; cyc();
    song_clk = 1'b0;
    note_on = 1'b1; note_trigger = 1'b0; phase_inc = 18'h10000; sample_clk = 1'b1;
    cyc();
    tick_clk = 1'b0; note_on = 1'b0;
    checks++;
    if (audio_out !== 13'd0 || dut.vol_r !== 8'd108)
      $display("FAIL old_inc_gate: audio %0d vol %0d expected 0 108", audio_out, dut.vol_r);
    else passed++;
    cyc(); cyc(); sample_clk = 1'b0;
    tick_clk = 1'b1; cyc(); tick_clk = 1'b0;
    checks++;
    if (audio_out !== 13'd1728) $display("FAIL new_inc_gate: got %0d expected 1728", audio_out);
    else passed++;
  endtask

  task automatic test_wrap14();
    logic [13:0] ph14;
    latch_row(1'b1, 1'b1, 18'h00000, 14'h03FF);
    ph14 = 14'h0;
    sample_clk = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      ph14 = ph14 + 14'h03FF;
      exp_q.push_back(ph14[13] ? 13'd4080 : 13'd0);
      cyc();
      exp_v = exp_q.pop_front();
      checks++;
      if (audio_out14 !== exp_v)
        $display("FAIL wrap14_sample%0d: got %0d expected %0d", n, audio_out14, exp_v);
      else passed++;
    end
    sample_clk = 1'b0;
    checks++;
    if (dut14.phase_r !== ph14) $display("FAIL wrap14_phase: got %0h expected %0h", dut14.phase_r, ph14);
    else passed++;
  endtask

  task automatic test_reset_mid();
    latch_row(1'b1, 1'b1, 18'h20000, 14'h0000);
    sample_clk = 1'b1; cyc(); sample_clk = 1'b0;
    checks++;
    if (audio_out !== 13'd4080) $display("FAIL pre_reset: got %0d expected 4080", audio_out);
    else passed++;
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    checks++;
    if (audio_out !== 13'd0 || audio_out14 !== 13'd0)
      $display("FAIL mid_reset: got %0d %0d expected 0 0", audio_out, audio_out14);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0; sample_clk = 1'b0; tick_clk = 1'b0; song_clk = 1'b0;
    note_on = 1'b0; note_trigger = 1'b0; phase_inc = 18'h0; phase_inc14 = 14'h0;
    test_reset();
    test_trigger_pitch();
    test_release();
    test_latch_timing();
    test_conflicts();
    test_wrap14();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
